// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time to the
// instruction MMU/cache, and buffers returned words in a small FIFO for decode.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              addr_i_o,
    output logic                     ena_i_o,
    input  logic [31:0]              data_i_i,
    input  logic                     valid_i_i,
    input  logic                     except_i_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              pc_o,
    output logic                     inst_except_o,
    output logic                     inst_valid_o,
    input  logic                     inst_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_addr_q;
    logic          ena_q;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic          exc_mem_q  [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_after_pop;

    logic          pop;
    logic          push;
    logic          flush;
    logic [31:0]   push_pc;
    logic [31:0]   push_data;
    logic          push_exc;

    // A redirect suppresses any push; a misaligned fetch PC becomes an exception entry.
    always_comb begin
        pop             = (count_q != '0) && inst_ready_i;
        count_after_pop = count_q - CW'(pop);
        flush           = redirect_i;
        push            = 1'b0;
        push_pc         = fetch_addr_q;
        push_data       = data_i_i;
        push_exc        = except_i_i;
        case (state_q)
            IDLE: begin
                if (!redirect_i && (count_after_pop < FULL) && (fetch_pc_q[1:0] != 2'b00)) begin
                    push      = 1'b1;
                    push_pc   = fetch_pc_q;
                    push_data = '0;
                    push_exc  = 1'b1;
                end
            end
            REQ: begin
                if (!redirect_i && valid_i_i) begin
                    push = 1'b1;
                end
            end
            default: ;
        endcase
        count_d = flush ? '0 : (count_after_pop + CW'(push));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            ena_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_i;
                    end else if (count_after_pop < FULL) begin
                        if (fetch_pc_q[1:0] != 2'b00) begin
                            state_q <= HALT;
                        end else begin
                            fetch_addr_q <= fetch_pc_q;
                            ena_q        <= 1'b1;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    // The part needs a stable request, so an unanswered redirect waits in DISCARD.
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_i;
                        if (valid_i_i) begin
                            ena_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end else if (valid_i_i) begin
                        fetch_pc_q <= fetch_addr_q + 32'd4;
                        if (except_i_i) begin
                            ena_q   <= 1'b0;
                            state_q <= HALT;
                        end else if (count_d < FULL) begin
                            fetch_addr_q <= fetch_addr_q + 32'd4;
                        end else begin
                            ena_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_i;
                    end
                    if (valid_i_i) begin
                        ena_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                HALT: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_i;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    ena_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
                exc_mem_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                inst_mem_q[tail_q] <= push_data;
                pc_mem_q[tail_q]   <= push_pc;
                exc_mem_q[tail_q]  <= push_exc;
                tail_q             <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign addr_i_o      = fetch_addr_q;
    assign ena_i_o       = ena_q;
    assign inst_o        = inst_mem_q[head_q];
    assign pc_o          = pc_mem_q[head_q];
    assign inst_except_o = exc_mem_q[head_q];
    assign inst_valid_o  = (count_q != '0);
    assign count_o       = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue; the bench plays the instruction part
// and decode, driving inputs on the falling edge and checking outputs there too.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i_o;
    logic        ena_i_o;
    logic [31:0] data_i_i = '0;
    logic        valid_i_i = 1'b0;
    logic        except_i_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_except_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [2:0]  count_o;

    int passed = 0;
    int total  = 0;

    ifetch_queue #(.RESET_PC(32'hBFC00000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .addr_i_o(addr_i_o), .ena_i_o(ena_i_o),
        .data_i_i(data_i_i), .valid_i_i(valid_i_i), .except_i_i(except_i_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_o(inst_o), .pc_o(pc_o), .inst_except_o(inst_except_o),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Instruction word the bench's part returns for a given PC.
    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A0F0F;
    endfunction

    // One-cycle response strobe from the part, starting at a falling edge.
    task automatic respond(input logic [31:0] d, input logic e);
        valid_i_i  = 1'b1;
        data_i_i   = d;
        except_i_i = e;
        @(negedge clk);
        valid_i_i  = 1'b0;
        except_i_i = 1'b0;
        data_i_i   = '0;
    endtask

    task automatic redirect(input logic [31:0] pc, input logic with_valid);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        valid_i_i     = with_valid;
        data_i_i      = 32'hDEADBEEF;
        @(negedge clk);
        redirect_i = 1'b0;
        valid_i_i  = 1'b0;
        data_i_i   = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (ena_i_o !== 1'b0) $display("[TB] FAIL reset_ena: got %b want 0", ena_i_o); else passed++;
        total++; if (addr_i_o !== 32'hBFC00000) $display("[TB] FAIL reset_addr: got %h want BFC00000", addr_i_o); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", inst_valid_o); else passed++;
        total++; if (count_o !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", count_o); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (ena_i_o !== 1'b1) $display("[TB] FAIL first_ena: got %b want 1", ena_i_o); else passed++;
        total++; if (addr_i_o !== 32'hBFC00000) $display("[TB] FAIL first_addr: got %h want BFC00000", addr_i_o); else passed++;
    endtask

    task automatic test_fetch();
        logic [31:0] pc;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 32'hBFC00000 + 32'(4 * k);
            @(negedge clk);
            total++; if (addr_i_o !== pc) $display("[TB] FAIL fetch_addr%0d: got %h want %h", k, addr_i_o, pc); else passed++;
            respond(word_of(pc), 1'b0);
            total++; if (inst_valid_o !== 1'b1) $display("[TB] FAIL fetch_valid%0d: got %b want 1", k, inst_valid_o); else passed++;
            total++; if (pc_o !== pc) $display("[TB] FAIL fetch_pc%0d: got %h want %h", k, pc_o, pc); else passed++;
            total++; if (inst_o !== word_of(pc)) $display("[TB] FAIL fetch_inst%0d: got %h want %h", k, inst_o, word_of(pc)); else passed++;
        end
        @(negedge clk);
        total++; if (count_o !== 3'd0) $display("[TB] FAIL fetch_drained: got %0d want 0", count_o); else passed++;
        total++; if (addr_i_o !== 32'hBFC0000C) $display("[TB] FAIL fetch_next_addr: got %h want BFC0000C", addr_i_o); else passed++;
    endtask

    task automatic test_full();
        logic [31:0] pc;
        inst_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pc = 32'hBFC0000C + 32'(4 * k);
            total++; if (addr_i_o !== pc || ena_i_o !== 1'b1) $display("[TB] FAIL full_req%0d: got %h/%b want %h/1", k, addr_i_o, ena_i_o, pc); else passed++;
            respond(word_of(pc), 1'b0);
        end
        total++; if (count_o !== 3'd4) $display("[TB] FAIL full_count: got %0d want 4", count_o); else passed++;
        total++; if (ena_i_o !== 1'b0) $display("[TB] FAIL full_ena: got %b want 0", ena_i_o); else passed++;
        repeat (16) @(negedge clk);
        total++; if (count_o !== 3'd4 || ena_i_o !== 1'b0) $display("[TB] FAIL full_hold: got %0d/%b want 4/0", count_o, ena_i_o); else passed++;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pc = 32'hBFC0000C + 32'(4 * k);
            total++; if (pc_o !== pc || inst_o !== word_of(pc)) $display("[TB] FAIL drain%0d: got %h/%h want %h/%h", k, pc_o, inst_o, pc, word_of(pc)); else passed++;
            @(negedge clk);
        end
        total++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL drain_empty: got %b want 0", inst_valid_o); else passed++;
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'hBFC0001C) $display("[TB] FAIL resume: got %b/%h want 1/BFC0001C", ena_i_o, addr_i_o); else passed++;
    endtask

    task automatic test_redirect_outstanding();
        inst_ready_i = 1'b0;
        respond(word_of(32'hBFC0001C), 1'b0);
        total++; if (count_o !== 3'd1) $display("[TB] FAIL ro_prefill: got %0d want 1", count_o); else passed++;
        redirect(32'h80001000, 1'b0);
        inst_ready_i = 1'b1;
        total++; if (count_o !== 3'd0 || inst_valid_o !== 1'b0) $display("[TB] FAIL ro_flush: got %0d/%b want 0/0", count_o, inst_valid_o); else passed++;
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'hBFC00020) $display("[TB] FAIL ro_hold: got %b/%h want 1/BFC00020", ena_i_o, addr_i_o); else passed++;
        repeat (2) @(negedge clk);
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'hBFC00020) $display("[TB] FAIL ro_hold2: got %b/%h want 1/BFC00020", ena_i_o, addr_i_o); else passed++;
        respond(32'h12345678, 1'b0);
        total++; if (ena_i_o !== 1'b0 || count_o !== 3'd0) $display("[TB] FAIL ro_drop: got %b/%0d want 0/0", ena_i_o, count_o); else passed++;
        @(negedge clk);
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'h80001000) $display("[TB] FAIL ro_target: got %b/%h want 1/80001000", ena_i_o, addr_i_o); else passed++;
    endtask

    task automatic test_redirect_coincident();
        redirect(32'h80002000, 1'b1);
        total++; if (ena_i_o !== 1'b0 || count_o !== 3'd0) $display("[TB] FAIL rc_drop: got %b/%0d want 0/0", ena_i_o, count_o); else passed++;
        @(negedge clk);
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'h80002000) $display("[TB] FAIL rc_target: got %b/%h want 1/80002000", ena_i_o, addr_i_o); else passed++;
        total++; if (count_o !== 3'd0) $display("[TB] FAIL rc_count: got %0d want 0", count_o); else passed++;
    endtask

    task automatic test_exception();
        logic [31:0] pc;
        redirect(32'h00400000, 1'b1);
        inst_ready_i = 1'b0;
        @(negedge clk);
        total++; if (addr_i_o !== 32'h00400000) $display("[TB] FAIL ex_addr: got %h want 00400000", addr_i_o); else passed++;
        respond(word_of(32'h00400000), 1'b0);
        respond(word_of(32'h00400004), 1'b0);
        respond(word_of(32'h00400008), 1'b1);
        total++; if (ena_i_o !== 1'b0 || count_o !== 3'd3) $display("[TB] FAIL ex_halt: got %b/%0d want 0/3", ena_i_o, count_o); else passed++;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h00400000 + 32'(4 * k);
            total++; if (pc_o !== pc || inst_except_o !== (k == 2)) $display("[TB] FAIL ex_pop%0d: got %h/%b want %h/%b", k, pc_o, inst_except_o, pc, (k == 2)); else passed++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (ena_i_o !== 1'b0 || count_o !== 3'd0) $display("[TB] FAIL ex_stay: got %b/%0d want 0/0", ena_i_o, count_o); else passed++;
        redirect(32'h80000180, 1'b0);
        @(negedge clk);
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'h80000180) $display("[TB] FAIL ex_resume: got %b/%h want 1/80000180", ena_i_o, addr_i_o); else passed++;
    endtask

    task automatic test_misaligned();
        inst_ready_i = 1'b0;
        redirect(32'h80000002, 1'b1);
        @(negedge clk);
        total++; if (count_o !== 3'd1 || inst_valid_o !== 1'b1) $display("[TB] FAIL mis_count: got %0d/%b want 1/1", count_o, inst_valid_o); else passed++;
        total++; if (pc_o !== 32'h80000002 || inst_except_o !== 1'b1 || inst_o !== 32'h0) $display("[TB] FAIL mis_entry: got %h/%b/%h want 80000002/1/0", pc_o, inst_except_o, inst_o); else passed++;
        repeat (3) begin
            total++; if (ena_i_o !== 1'b0) $display("[TB] FAIL mis_noreq: got %b want 0", ena_i_o); else passed++;
            @(negedge clk);
        end
        total++; if (count_o !== 3'd1) $display("[TB] FAIL mis_halt: got %0d want 1", count_o); else passed++;
    endtask

    task automatic test_async_reset();
        redirect(32'h80000010, 1'b0);
        @(negedge clk);
        respond(word_of(32'h80000010), 1'b0);
        total++; if (ena_i_o !== 1'b1 || count_o !== 3'd1) $display("[TB] FAIL ar_pre: got %b/%0d want 1/1", ena_i_o, count_o); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (ena_i_o !== 1'b0 || addr_i_o !== 32'hBFC00000) $display("[TB] FAIL ar_req: got %b/%h want 0/BFC00000", ena_i_o, addr_i_o); else passed++;
        total++; if (count_o !== 3'd0 || inst_valid_o !== 1'b0) $display("[TB] FAIL ar_fifo: got %0d/%b want 0/0", count_o, inst_valid_o); else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (ena_i_o !== 1'b1 || addr_i_o !== 32'hBFC00000) $display("[TB] FAIL ar_restart: got %b/%h want 1/BFC00000", ena_i_o, addr_i_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_full();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_exception();
        test_misaligned();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
